// File: rtl/regime_watchdog.sv
// Watchdog over eigen-core results: classifies kappa/regime, debounces trips, flags stale core.
// Latency: one clk; a result accepted at edge N is visible on every output right after edge N.
// Backpressure: none; results arriving while en=0 or clr=1 are dropped.
module regime_watchdog #(
  parameter int          TRIP_N      = 3,
  parameter int          CLEAR_N     = 4,
  parameter int          TIMEOUT_CYC = 1024,
  parameter int          KW          = 32,
  // trip_total stops counting at this value; all-ones for the 16-bit counter
  parameter logic [15:0] TRIP_SAT    = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 res_valid,
  input  logic signed [KW-1:0] kappa,
  input  logic signed [KW-1:0] inv_kappa,
  input  logic [2:0]           regime,
  input  logic signed [KW-1:0] kappa_hi,
  input  logic signed [KW-1:0] kappa_lo,
  input  logic                 clr,
  output logic                 alarm,
  output logic                 warn,
  output logic [1:0]           wd_state,
  output logic                 stale,
  output logic                 regime_err,
  output logic [15:0]          trip_total,
  output logic [KW-1:0]        last_kappa
);

  typedef enum logic [1:0] {
    ST_OK      = 2'b00,
    ST_SUSPECT = 2'b01,
    ST_ALARM   = 2'b10,
    ST_RECOVER = 2'b11
  } wd_state_e;

  localparam int            TW      = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [TW-1:0] T_PRE   = TW'(TIMEOUT_CYC - 2);
  localparam logic [7:0]    TRIP_L  = 8'(TRIP_N);
  localparam logic [7:0]    CLEAR_L = 8'(CLEAR_N);

  wd_state_e      state_q, st_nxt;
  logic [7:0]     bad_cnt_q, bad_nxt;
  logic [7:0]     good_cnt_q, good_nxt;
  logic [TW-1:0]  timer_q;
  logic           stale_q, regime_err_q, alarm_q, warn_q;
  logic [15:0]    trip_total_q;
  logic [KW-1:0]  last_kappa_q;

  logic accept, onehot, under, is_bad, is_good, timeout_hit, enter_alarm;

  // inv_kappa travels with the result but plays no part in classification
  logic unused_inv;
  assign unused_inv = ^inv_kappa;

  // Classify the incoming result and detect the edge on which the timer expires
  always_comb begin
    accept      = en && res_valid && !clr;
    onehot      = (regime == 3'b100) || (regime == 3'b010) || (regime == 3'b001);
    under       = (regime == 3'b001);
    is_bad      = !onehot || (under && (kappa >= kappa_hi));
    is_good     = onehot && (!under || (kappa <= kappa_lo));
    // once the timer sits at T_LAST it no longer matches T_PRE, so no repeated trips
    timeout_hit = en && !accept && !clr && (timer_q == T_PRE);
  end

  // Next state and debounce counters; every ALARM entry clears both counters
  always_comb begin
    st_nxt   = state_q;
    bad_nxt  = bad_cnt_q;
    good_nxt = good_cnt_q;
    if (accept) begin
      if (!onehot) begin
        st_nxt   = ST_ALARM;
        bad_nxt  = 8'd0;
        good_nxt = 8'd0;
      end else begin
        case (state_q)
          ST_OK: begin
            if (is_bad) begin
              if (TRIP_L <= 8'd1) begin
                st_nxt  = ST_ALARM;
                bad_nxt = 8'd0;
              end else begin
                st_nxt  = ST_SUSPECT;
                bad_nxt = 8'd1;
              end
            end
          end
          ST_SUSPECT: begin
            if (is_bad) begin
              if (bad_cnt_q + 8'd1 >= TRIP_L) begin
                st_nxt  = ST_ALARM;
                bad_nxt = 8'd0;
              end else begin
                bad_nxt = bad_cnt_q + 8'd1;
              end
            end else if (is_good) begin
              st_nxt  = ST_OK;
              bad_nxt = 8'd0;
            end
          end
          ST_ALARM: begin
            if (is_good) begin
              if (CLEAR_L <= 8'd1) begin
                st_nxt   = ST_OK;
                good_nxt = 8'd0;
              end else begin
                st_nxt   = ST_RECOVER;
                good_nxt = 8'd1;
              end
            end
          end
          default: begin
            if (is_good) begin
              if (good_cnt_q + 8'd1 >= CLEAR_L) begin
                st_nxt   = ST_OK;
                good_nxt = 8'd0;
              end else begin
                good_nxt = good_cnt_q + 8'd1;
              end
            end else if (is_bad) begin
              st_nxt   = ST_ALARM;
              good_nxt = 8'd0;
            end
          end
        endcase
      end
    end else if (timeout_hit) begin
      st_nxt   = ST_ALARM;
      bad_nxt  = 8'd0;
      good_nxt = 8'd0;
    end
    enter_alarm = (st_nxt == ST_ALARM) && (state_q != ST_ALARM);
  end

  // All watchdog state and registered outputs; clr outranks everything but reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_OK;
      bad_cnt_q    <= 8'd0;
      good_cnt_q   <= 8'd0;
      timer_q      <= '0;
      stale_q      <= 1'b0;
      regime_err_q <= 1'b0;
      trip_total_q <= 16'd0;
      last_kappa_q <= '0;
      alarm_q      <= 1'b0;
      warn_q       <= 1'b0;
    end else if (clr) begin
      state_q      <= ST_OK;
      bad_cnt_q    <= 8'd0;
      good_cnt_q   <= 8'd0;
      timer_q      <= '0;
      stale_q      <= 1'b0;
      regime_err_q <= 1'b0;
      alarm_q      <= 1'b0;
      warn_q       <= 1'b0;
    end else begin
      state_q    <= st_nxt;
      bad_cnt_q  <= bad_nxt;
      good_cnt_q <= good_nxt;
      alarm_q    <= (st_nxt == ST_ALARM) || (st_nxt == ST_RECOVER);
      warn_q     <= (st_nxt == ST_SUSPECT);
      if (enter_alarm && (trip_total_q != TRIP_SAT)) begin
        trip_total_q <= trip_total_q + 16'd1;
      end
      if (accept) begin
        last_kappa_q <= kappa;
      end
      if (accept && !onehot) begin
        regime_err_q <= 1'b1;
      end
      if (!en || accept) begin
        timer_q <= '0;
      end else if (timer_q != T_LAST) begin
        timer_q <= timer_q + 1'b1;
      end
      if (accept) begin
        stale_q <= 1'b0;
      end else if (timeout_hit) begin
        stale_q <= 1'b1;
      end
    end
  end

  assign wd_state   = state_q;
  assign alarm      = alarm_q;
  assign warn       = warn_q;
  assign stale      = stale_q;
  assign regime_err = regime_err_q;
  assign trip_total = trip_total_q;
  assign last_kappa = last_kappa_q;

endmodule

// File: tb/tb_regime_watchdog.sv
// Directed bench for regime_watchdog: debounce, invalid regime, clr, timeout, en, saturation, reset.
// Main instance uses TIMEOUT_CYC=16; a second instance (TRIP_N=CLEAR_N=1, low saturation) covers counter limits.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_regime_watchdog;

  logic        clk = 1'b0;
  logic        rst_n, en, res_valid, clr;
  logic [31:0] kappa, inv_kappa, kappa_hi, kappa_lo;
  logic [2:0]  regime;

  logic        alarm, warn, stale, regime_err;
  logic [1:0]  wd_state;
  logic [15:0] trip_total;
  logic [31:0] last_kappa;

  logic        alarm2, warn2, stale2, regime_err2;
  logic [1:0]  wd_state2;
  logic [15:0] trip_total2;
  logic [31:0] last_kappa2;

  int n_chk = 0;
  int n_bad = 0;

  localparam logic [31:0] K_BAD  = 32'h0006_0000;
  localparam logic [31:0] K_NEUT = 32'h0004_0000;

  always #5 clk = ~clk;

  regime_watchdog #(.TRIP_N(3), .CLEAR_N(4), .TIMEOUT_CYC(16), .KW(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .res_valid(res_valid), .kappa(kappa),
    .inv_kappa(inv_kappa), .regime(regime), .kappa_hi(kappa_hi), .kappa_lo(kappa_lo),
    .clr(clr), .alarm(alarm), .warn(warn), .wd_state(wd_state), .stale(stale),
    .regime_err(regime_err), .trip_total(trip_total), .last_kappa(last_kappa)
  );

  regime_watchdog #(.TRIP_N(1), .CLEAR_N(1), .TIMEOUT_CYC(1024), .KW(32), .TRIP_SAT(16'd8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .en(en), .res_valid(res_valid), .kappa(kappa),
    .inv_kappa(inv_kappa), .regime(regime), .kappa_hi(kappa_hi), .kappa_lo(kappa_lo),
    .clr(clr), .alarm(alarm2), .warn(warn2), .wd_state(wd_state2), .stale(stale2),
    .regime_err(regime_err2), .trip_total(trip_total2), .last_kappa(last_kappa2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] r, input logic [31:0] k);
    res_valid = 1'b1;
    regime    = r;
    kappa     = k;
    inv_kappa = ~k;
    step(1);
    res_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; res_valid = 1'b0; clr = 1'b0;
    kappa = '0; inv_kappa = '0; regime = 3'b010;
    kappa_hi = 32'h0005_0000; kappa_lo = 32'h0003_0000;
    step(2);
    chk("rst_state", 32'(wd_state), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_warn", 32'(warn), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    chk("rst_rerr", 32'(regime_err), 32'd0);
    chk("rst_trips", 32'(trip_total), 32'd0);
    chk("rst_lastk", last_kappa, 32'd0);

    // 1: three bad results trip the alarm
    rst_n = 1'b1; en = 1'b1;
    send(3'b001, K_BAD);
    chk("t1_st1", 32'(wd_state), 32'd1);
    chk("t1_warn1", 32'(warn), 32'd1);
    send(3'b001, K_BAD);
    chk("t1_st2", 32'(wd_state), 32'd1);
    send(3'b001, K_BAD);
    chk("t1_st3", 32'(wd_state), 32'd2);
    chk("t1_alarm", 32'(alarm), 32'd1);
    chk("t1_warn3", 32'(warn), 32'd0);
    chk("t1_trips", 32'(trip_total), 32'd1);
    chk("t1_lastk", last_kappa, K_BAD);

    // 2: four good results recover
    send(3'b010, 32'd0);
    chk("t2_st1", 32'(wd_state), 32'd3);
    send(3'b010, 32'd0);
    chk("t2_st2", 32'(wd_state), 32'd3);
    send(3'b010, 32'd0);
    chk("t2_st3", 32'(wd_state), 32'd3);
    chk("t2_alarm3", 32'(alarm), 32'd1);
    send(3'b010, 32'd0);
    chk("t2_st4", 32'(wd_state), 32'd0);
    chk("t2_alarm4", 32'(alarm), 32'd0);
    chk("t2_trips", 32'(trip_total), 32'd1);

    // 3: neutral holds the SUSPECT count, then thresholds and signed compares
    send(3'b001, K_BAD);
    send(3'b001, K_BAD);
    send(3'b001, K_NEUT);
    chk("t3_neut", 32'(wd_state), 32'd1);
    send(3'b001, K_BAD);
    chk("t3_trip", 32'(wd_state), 32'd2);
    chk("t3_trips", 32'(trip_total), 32'd2);
    send(3'b001, K_NEUT);
    chk("t3_alm_neut", 32'(wd_state), 32'd2);
    for (int i = 0; i < 4; i++) send(3'b100, K_BAD);
    chk("t3_back_ok", 32'(wd_state), 32'd0);
    send(3'b001, 32'h0005_0000);
    chk("t3_eq_hi", 32'(wd_state), 32'd1);
    send(3'b001, 32'h0003_0000);
    chk("t3_eq_lo", 32'(wd_state), 32'd0);
    send(3'b001, K_BAD);
    send(3'b001, 32'h8000_0000);
    chk("t3_neg", 32'(wd_state), 32'd0);
    send(3'b001, 32'h0003_0001);
    chk("t3_ok_neut", 32'(wd_state), 32'd0);

    // 4: invalid regime goes straight to ALARM; clr drops a same-cycle result
    send(3'b011, 32'h0001_2345);
    chk("t4_st", 32'(wd_state), 32'd2);
    chk("t4_rerr", 32'(regime_err), 32'd1);
    chk("t4_trips", 32'(trip_total), 32'd3);
    chk("t4_lastk", last_kappa, 32'h0001_2345);
    clr = 1'b1;
    send(3'b001, K_BAD);
    clr = 1'b0;
    chk("t4_clr_st", 32'(wd_state), 32'd0);
    chk("t4_clr_rerr", 32'(regime_err), 32'd0);
    chk("t4_clr_alarm", 32'(alarm), 32'd0);
    chk("t4_clr_trips", 32'(trip_total), 32'd3);
    chk("t4_clr_lastk", last_kappa, 32'h0001_2345);

    // 5: timeout after 15 idle enabled edges, trips once only
    step(14);
    chk("t5_pre_stale", 32'(stale), 32'd0);
    chk("t5_pre_st", 32'(wd_state), 32'd0);
    step(1);
    chk("t5_stale", 32'(stale), 32'd1);
    chk("t5_st", 32'(wd_state), 32'd2);
    chk("t5_trips", 32'(trip_total), 32'd4);
    step(100);
    chk("t5_hold_trips", 32'(trip_total), 32'd4);
    chk("t5_hold_stale", 32'(stale), 32'd1);
    send(3'b010, 32'd0);
    chk("t5_unstale", 32'(stale), 32'd0);
    chk("t5_recov", 32'(wd_state), 32'd3);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    step(14);
    send(3'b010, 32'h1111_0000);
    chk("t5_coinc_stale", 32'(stale), 32'd0);
    chk("t5_coinc_st", 32'(wd_state), 32'd0);
    step(14);
    chk("t5_after_stale", 32'(stale), 32'd0);

    // en=0: results ignored, timer held
    en = 1'b0;
    send(3'b001, K_BAD);
    chk("en0_st", 32'(wd_state), 32'd0);
    chk("en0_lastk", last_kappa, 32'h1111_0000);
    step(30);
    chk("en0_stale", 32'(stale), 32'd0);
    chk("en0_trips", 32'(trip_total), 32'd4);

    // 6: saturation on the low-limit instance, then reset from RECOVER
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1; en = 1'b1;
    send(3'b001, K_BAD);
    chk("t6_d2_trip", 32'(wd_state2), 32'd2);
    send(3'b010, 32'd0);
    chk("t6_d2_ok", 32'(wd_state2), 32'd0);
    for (int i = 0; i < 6; i++) begin
      send(3'b001, K_BAD);
      send(3'b010, 32'd0);
    end
    chk("t6_d2_seven", 32'(trip_total2), 32'd7);
    for (int i = 0; i < 3; i++) begin
      send(3'b001, K_BAD);
      send(3'b010, 32'd0);
    end
    chk("t6_d2_sat", 32'(trip_total2), 32'd8);
    chk("t6_d1_trips", 32'(trip_total), 32'd0);
    for (int i = 0; i < 3; i++) send(3'b001, K_BAD);
    send(3'b010, 32'd0);
    chk("t6_recover", 32'(wd_state), 32'd3);
    rst_n = 1'b0;
    send(3'b001, K_BAD);
    rst_n = 1'b1;
    chk("t6_rst_st", 32'(wd_state), 32'd0);
    chk("t6_rst_alarm", 32'(alarm), 32'd0);
    chk("t6_rst_trips", 32'(trip_total), 32'd0);
    chk("t6_rst_lastk", last_kappa, 32'd0);
    chk("t6_rst_d2_trips", 32'(trip_total2), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/regime_watchdog.md
Name: regime_watchdog

Overview:
- Downstream consumer of the eigenvalue core's results: kappa (Q16.16), inv_kappa and the one-hot damping regime.
- Classifies each result, debounces bad results with trip and recovery counters, and detects a stale core (no result within a timeout).
- Drives the registered alarm and warning outputs of the watchdog.

Parameters:
TRIP_N, 3, consecutive bad results needed to go SUSPECT -> ALARM (1..255)
CLEAR_N, 4, consecutive good results needed to go RECOVER -> OK (1..255)
TIMEOUT_CYC, 1024, max cycles between res_valid pulses while enabled (>=2)
KW, 32, width of kappa/inv_kappa (signed, Q16.16 at default)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
en  in  1  watchdog enable; 0 = hold idle
res_valid  in  1  one-cycle pulse: kappa/inv_kappa/regime valid this cycle
kappa  in  KW  signed kappa from eig core
inv_kappa  in  KW  signed 1/kappa from eig core
regime  in  3  100 overdamped, 010 critical, 001 underdamped
kappa_hi  in  KW  signed bad threshold
kappa_lo  in  KW  signed good threshold, kappa_lo <= kappa_hi
clr  in  1  synchronous clear pulse
alarm  out  1  high in ALARM and RECOVER
warn  out  1  high in SUSPECT
wd_state  out  2  00 OK, 01 SUSPECT, 10 ALARM, 11 RECOVER
stale  out  1  timeout occurred since last res_valid
regime_err  out  1  sticky: non-one-hot regime received
trip_total  out  16  saturating count of entries into ALARM
last_kappa  out  KW  kappa of the most recent accepted result

Behaviour:
- Reset (rst_n=0 at a clk edge) puts every output and all internal state to 0 (state OK): alarm, warn, stale, regime_err, trip_total, last_kappa, wd_state=00, bad_cnt, good_cnt and the timer.
- All outputs are registered. A result accepted at edge N is reflected in the outputs after edge N; there are no combinational paths from inputs to outputs.
- Accept condition: en && res_valid && !clr. On accept, last_kappa <= kappa. inv_kappa is not used for classification.
- Classification uses signed compares:
  - invalid: regime not one-hot (000, 011, 101, 110, 111).
  - bad: invalid, or (regime==001 && kappa >= kappa_hi).
  - good: valid and (regime!=001 || kappa <= kappa_lo).
  - neutral: neither (underdamped with kappa_lo < kappa < kappa_hi).
- Invalid result: regime_err <= 1 (sticky). The state goes directly to ALARM from any state.
- FSM on an accepted result:
  - OK: bad -> bad_cnt=1, then ALARM if TRIP_N==1, else SUSPECT. Good or neutral -> stay.
  - SUSPECT: bad -> bad_cnt++; ALARM when bad_cnt reaches TRIP_N. Good -> OK, bad_cnt=0. Neutral -> stay, count held.
  - ALARM: good -> good_cnt=1, then OK if CLEAR_N==1, else RECOVER. Bad or neutral -> stay.
  - RECOVER: good -> good_cnt++; OK when good_cnt reaches CLEAR_N. Bad -> ALARM, good_cnt=0. Neutral -> stay.
- Every transition into ALARM from a non-ALARM state increments trip_total, saturating at 0xFFFF. RECOVER -> ALARM counts as an entry.
- Timeout:
  - While en=1, the timer increments each cycle and resets to 0 on an accepted result.
  - When the timer reaches TIMEOUT_CYC-1 without an accept: stale <= 1, state -> ALARM (trip_total counted if entering ALARM), and the timer holds (saturates) with no repeated trips.
  - stale clears on the next accepted result; that same result is also classified normally.
  - If an accept and the timeout coincide on the same edge, the accept wins: timer resets and no stale.
- clr (priority over everything except reset):
  - state OK; bad_cnt, good_cnt, timer, stale and regime_err cleared.
  - trip_total and last_kappa kept.
  - A res_valid in the same cycle is dropped.
- en=0: results ignored, timer held at 0, state and flags held. Deasserting en does not clear an alarm.
- Reset mid-operation: on the next edge with rst_n=0 the block returns to the reset state, regardless of pending counts or timer.

Test Plan:
1. Reset, en=1, kappa_hi=0x00050000, kappa_lo=0x00030000; three res_valid with regime=001, kappa=0x00060000 -> wd_state 01, 01, 10; alarm=1 after the 3rd; trip_total=1.
2. From ALARM, four results with regime=010, kappa=0 -> wd_state 11, 11, 11, 00; alarm drops the cycle after the 4th; trip_total stays 1.
3. In SUSPECT (bad_cnt=2), send neutral kappa=0x00040000 then bad 0x00060000 -> SUSPECT held, then ALARM on the bad result. Bad then good from OK -> SUSPECT then OK.
4. regime=3'b011 while in OK -> next cycle wd_state=10, regime_err=1, trip_total+1. Then clr -> OK, regime_err=0, trip_total unchanged.
5. TIMEOUT_CYC=16, en=1, no res_valid -> stale=1 and ALARM after 15 cycles, trip_total+1 exactly once over a further 100 idle cycles. A res_valid on the same edge the timer hits 15 -> no stale.
6. trip_total preset near 0xFFFF via repeated trips -> saturates at 0xFFFF. rst_n=0 for one edge while in RECOVER -> all outputs 0.
